dht11_ctrl: RTL and testbench
=============================

DHT11_CTRL -- requirements
Module: dht11_ctrl

Interface
REQ-001 Parameter START_TICKS, default 2000, host start-low duration in 10 us ticks (20 ms).
REQ-002 Parameter TIMEOUT_TICKS, default 10, maximum ticks allowed in any sensor-driven phase (100 us).
REQ-003 Parameter BIT1_THRESH, default 5, minimum high-phase tick count decoded as bit 1.
REQ-004 Port clk, input, 1, 12 MHz system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, reset, synchronous and active-high.
REQ-006 Port clk_100khz, input, 1, 100 kHz divided clock from the divider, registered in the clk domain; used only as a data signal, never as a clock.
REQ-007 Port start, input, 1, one-cycle request to begin a measurement.
REQ-008 Port dht_in, input, 1, raw level of the sensor data pin.
REQ-009 Port dht_oe, output, 1, 1 = drive pin low; 0 = release (pulled up externally).
REQ-010 Port busy, output, 1, high while a transaction is in progress.
REQ-011 Port humi_int / humi_dec / temp_int / temp_dec, output, 8 each, last checksum-valid measurement.
REQ-012 Port data_valid, output, 1, one-cycle pulse when the data outputs update.
REQ-013 Port err, output, 1, one-cycle pulse on timeout or checksum failure.

Function
REQ-014 tick SHALL be a one-clk pulse on each rising edge of clk_100khz (previous-value register, reset 0).
REQ-015 dht_in SHALL pass through a 2-FF synchronizer (reset 1); all protocol decisions SHALL use the synchronized value; rise/fall SHALL be detected against its registered copy.
REQ-016 A phase tick counter SHALL clear on every state entry and increment on tick only.
REQ-017 States SHALL be: IDLE, START_LOW, WAIT_RESP, RESP_L, RESP_H, BIT_L, BIT_H, CHECK, ERR.
REQ-018 IDLE: dht_oe=0, busy=0; start=1 -> START_LOW.
REQ-019 START_LOW: dht_oe=1; when the counter reaches START_TICKS -> WAIT_RESP with dht_oe=0 from the next cycle.
REQ-020 WAIT_RESP: falling edge -> RESP_L.
REQ-021 RESP_L: rising edge -> RESP_H.
REQ-022 RESP_H: falling edge -> BIT_L with the bit counter cleared.
REQ-023 BIT_L: rising edge -> BIT_H.
REQ-024 BIT_H: on the falling edge, shift in bit = (counter >= BIT1_THRESH), MSB first, into a 40-bit register.
REQ-025 After BIT_H bit 40 SHALL go to CHECK; otherwise -> BIT_L.
REQ-026 In WAIT_RESP, RESP_L, RESP_H, BIT_L and BIT_H, a counter value of TIMEOUT_TICKS SHALL cause ERR; an edge and the timeout in the same cycle SHALL resolve as the edge.
REQ-027 CHECK: byte0+byte1+byte2+byte3 modulo 256 SHALL be compared with byte4.
REQ-028 On a checksum match, CHECK SHALL load humi_int=byte0, humi_dec=byte1, temp_int=byte2, temp_dec=byte3 and pulse data_valid, then -> IDLE.
REQ-029 On a checksum mismatch, CHECK SHALL go to ERR with the outputs unchanged.
REQ-030 ERR SHALL pulse err for one cycle, then -> IDLE; data outputs SHALL hold.
REQ-031 Latency: data_valid SHALL assert exactly 2 clk cycles after the cycle in which the synchronized falling edge ending bit 40 is detected.
REQ-032 start while busy=1 SHALL be ignored; busy SHALL be 1 in every state except IDLE.
REQ-033 data_valid and err SHALL never assert in the same cycle.

Reset
REQ-034 With rst=1 at a clock edge: state=IDLE, dht_oe=0, busy=0, data_valid=0, err=0, all data outputs 0x00, shift register 0, counters 0.
REQ-035 rst mid-transaction SHALL abort it, releasing the pin on the first edge at which rst is sampled high.
REQ-036 After rst, no data_valid or err SHALL be produced for the aborted transaction.

Verification
REQ-037 Sensor model replies 0x37,0x00,0x19,0x00,0x50 -> dht_oe high 2000 ticks, then data_valid once; humi_int=0x37, temp_int=0x19.
REQ-038 Same frame but checksum 0x51 -> err pulse once, data outputs keep their previous values, no data_valid.
REQ-039 No sensor response (line held high) -> err pulse when the WAIT_RESP counter reaches 10 ticks (approx. 100 us after release).
REQ-040 Bit high widths of 40 us (4 ticks) and 50 us (5 ticks) -> decoded as 0 and 1 respectively.
REQ-041 rst asserted during BIT_H of bit 20 -> dht_oe=0, busy=0 next cycle; a subsequent start completes normally.
REQ-042 start pulsed while in RESP_L -> ignored; exactly one data_valid for the transaction.

Source files
------------

// File: rtl/dht11_ctrl.sv
`timescale 1ns/1ps
// dht11_ctrl: single-wire DHT11 host controller.
// Issues the start pulse, times the sensor's response and 40 data bits in
// 10 us ticks, checks the checksum and publishes the last good reading.
module dht11_ctrl #(
  parameter int START_TICKS   = 2000,
  parameter int TIMEOUT_TICKS = 10,
  parameter int BIT1_THRESH   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_100khz,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic [7:0] humi_int,
  output logic [7:0] humi_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       err
);

  // Wide enough for the start pulse; sensor phases never get past the timeout.
  localparam int CNT_W = $clog2(START_TICKS + TIMEOUT_TICKS + 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_L, RESP_H, BIT_L, BIT_H, CHECK, ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [39:0]      shift_q, shift_d;
  logic [7:0]       humi_int_q, humi_int_d;
  logic [7:0]       humi_dec_q, humi_dec_d;
  logic [7:0]       temp_int_q, temp_int_d;
  logic [7:0]       temp_dec_q, temp_dec_d;
  logic             data_valid_q, data_valid_d;
  logic             err_q, err_d;
  logic             clk100_q, clk100_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             din_q, din_d;

  logic             tick;
  logic             din_fall;
  logic             din_rise;
  logic             timeout;
  logic             bit_val;
  logic [7:0]       csum;

  // Input pipeline: divided-clock history, 2-FF pin synchronizer, edge history
  always_comb begin
    clk100_d = clk_100khz;
    sync1_d  = dht_in;
    sync2_d  = sync1_q;
    din_d    = sync2_q;
  end

  assign tick     = clk_100khz & ~clk100_q;
  assign din_fall = din_q & ~sync2_q;
  assign din_rise = ~din_q & sync2_q;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_TICKS));
  assign bit_val  = (cnt_q >= CNT_W'(BIT1_THRESH));
  assign csum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  // Next-state, datapath updates and pin/busy outputs for the protocol FSM
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    humi_int_d   = humi_int_q;
    humi_dec_d   = humi_dec_q;
    temp_int_d   = temp_int_q;
    temp_dec_d   = temp_dec_q;
    data_valid_d = 1'b0;
    err_d        = 1'b0;
    dht_oe       = 1'b0;
    busy         = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) state_d = START_LOW;
      end
      START_LOW: begin
        dht_oe = 1'b1;
        if (cnt_q == CNT_W'(START_TICKS)) state_d = WAIT_RESP;
      end
      // In each sensor-driven phase an edge beats a same-cycle timeout.
      WAIT_RESP: begin
        if (din_fall)     state_d = RESP_L;
        else if (timeout) state_d = ERR;
      end
      RESP_L: begin
        if (din_rise)     state_d = RESP_H;
        else if (timeout) state_d = ERR;
      end
      RESP_H: begin
        if (din_fall) begin
          state_d   = BIT_L;
          bit_cnt_d = '0;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      BIT_L: begin
        if (din_rise)     state_d = BIT_H;
        else if (timeout) state_d = ERR;
      end
      BIT_H: begin
        if (din_fall) begin
          shift_d   = {shift_q[38:0], bit_val};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? CHECK : BIT_L;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      CHECK: begin
        if (csum == shift_q[7:0]) begin
          humi_int_d   = shift_q[39:32];
          humi_dec_d   = shift_q[31:24];
          temp_int_d   = shift_q[23:16];
          temp_dec_d   = shift_q[15:8];
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = ERR;
        end
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Phase timer restarts on every state change and otherwise counts ticks.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(tick);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      // NOTE: the 40-bit shift register is reset as well; it is flops, not
      // RAM, and a clean value keeps a stale frame from ever leaking out.
      shift_q      <= '0;
      humi_int_q   <= '0;
      humi_dec_q   <= '0;
      temp_int_q   <= '0;
      temp_dec_q   <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      clk100_q     <= 1'b0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      din_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      humi_int_q   <= humi_int_d;
      humi_dec_q   <= humi_dec_d;
      temp_int_q   <= temp_int_d;
      temp_dec_q   <= temp_dec_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      clk100_q     <= clk100_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      din_q        <= din_d;
    end
  end

  assign humi_int   = humi_int_q;
  assign humi_dec   = humi_dec_q;
  assign temp_int   = temp_int_q;
  assign temp_dec   = temp_dec_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dht11_ctrl.sv
`timescale 1ns/1ps
// tb_dht11_ctrl: drives a behavioural DHT11 sensor with randomized timing and
// compares the controller against a frame-level reference model.
module tb_dht11_ctrl;

  localparam int BIT1_THRESH = 5;

  logic       clk, rst, clk_100khz, start, dht_in;
  logic       dht_oe, busy, data_valid, err;
  logic [7:0] humi_int, humi_dec, temp_int, temp_dec;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Reference model of the published reading
  logic [7:0] exp_hi, exp_hd, exp_ti, exp_td;

  dht11_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_100khz (clk_100khz),
    .start      (start),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .busy       (busy),
    .humi_int   (humi_int),
    .humi_dec   (humi_dec),
    .temp_int   (temp_int),
    .temp_dec   (temp_dec),
    .data_valid (data_valid),
    .err        (err)
  );

  // System clock: posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scaled "100 kHz" tick source: one rise every 3 system clocks, at 30k+10
  initial begin
    clk_100khz = 1'b0;
    #10;
    forever begin
      clk_100khz = 1'b1;
      #10;
      clk_100khz = 1'b0;
      #20;
    end
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_valid)        dv_cnt++;
      if (err)               err_cnt++;
      if (data_valid && err) both_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_humi_int"}, humi_int, exp_hi);
    check({tag, "_humi_dec"}, humi_dec, exp_hd);
    check({tag, "_temp_int"}, temp_int, exp_ti);
    check({tag, "_temp_dec"}, temp_dec, exp_td);
  endtask

  function automatic logic [39:0] mk_frame(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input bit bad);
    int s;
    s = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
    return {b0, b1, b2, b3, 8'(s) ^ {7'd0, bad}};
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk_100khz);
  endtask

  // mode: 0 random widths, 1 boundary widths (4/5 ticks), 2 reset during
  // bit 20, 3 start pulse during the response low, 4 sensor never answers.
  task automatic do_txn(input string name, input logic [39:0] frame, input int mode);
    int          dv0, er0, n, hi, s;
    logic [39:0] dec;
    bit          good;
    dv0 = dv_cnt;
    er0 = err_cnt;

    // Start request aligned to a tick source rise
    @(posedge clk_100khz);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1);

    // Count whole ticks with the pin driven low
    n = 0;
    @(posedge clk_100khz);
    while (dht_oe && n <= 2100) begin
      n++;
      @(posedge clk_100khz);
    end
    check({name, "_start_low_ticks"}, n, 2000);

    if (mode == 4) begin
      #1;
      n = 0;
      while (!err && n < 100) begin
        @(negedge clk);
        n++;
      end
      // Cycles from release to err, rounded to whole ticks
      check({name, "_noresp_ticks"}, (n + 2) / 3, 10);
      repeat (3) @(negedge clk);
      check({name, "_err_count"}, err_cnt - er0, 1);
      check({name, "_dv_count"}, dv_cnt - dv0, 0);
      check({name, "_idle"}, busy, 0);
      check_outputs(name);
      return;
    end

    // Sensor response: low then high
    wait_ticks($urandom_range(4, 2));
    dht_in = 1'b0;
    if (mode == 3) begin
      n = $urandom_range(8, 4);
      wait_ticks(2);
      #1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ticks(n - 2);
    end else begin
      wait_ticks($urandom_range(8, 4));
    end
    dht_in = 1'b1;
    wait_ticks($urandom_range(8, 4));

    // 40 data bits, MSB first; the high width encodes the bit
    dec = '0;
    for (int i = 39; i >= 0; i--) begin
      dht_in = 1'b0;
      wait_ticks($urandom_range(7, 3));
      dht_in = 1'b1;
      if (mode == 2 && i == 20) begin
        wait_ticks(2);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({name, "_abort_oe"}, dht_oe, 0);
        check({name, "_abort_busy"}, busy, 0);
        rst = 1'b0;
        exp_hi = '0; exp_hd = '0; exp_ti = '0; exp_td = '0;
        wait_ticks(30);
        check({name, "_abort_dv"}, dv_cnt - dv0, 0);
        check({name, "_abort_err"}, err_cnt - er0, 0);
        check_outputs(name);
        return;
      end
      if (mode == 1) hi = frame[i] ? BIT1_THRESH : BIT1_THRESH - 1;
      else           hi = frame[i] ? $urandom_range(8, 5) : $urandom_range(4, 1);
      dec = {dec[38:0], (hi >= BIT1_THRESH)};
      wait_ticks(hi);
    end

    // Falling edge ending bit 40; data_valid expected 4 clk after the pin change
    dht_in = 1'b0;
    #1;
    n = 0;
    while (!data_valid && !err && n < 20) begin
      @(negedge clk);
      n++;
    end
    s    = (int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8])) % 256;
    good = (s == int'(dec[7:0]));
    if (good) begin
      check({name, "_dv_latency"}, n, 4);
      exp_hi = dec[39:32];
      exp_hd = dec[31:24];
      exp_ti = dec[23:16];
      exp_td = dec[15:8];
    end
    wait_ticks(5);
    dht_in = 1'b1;
    wait_ticks(3);
    check({name, "_dv_count"}, dv_cnt - dv0, good ? 1 : 0);
    check({name, "_err_count"}, err_cnt - er0, good ? 0 : 1);
    check({name, "_idle"}, busy, 0);
    check_outputs(name);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    dht_in = 1'b1;
    exp_hi = '0; exp_hd = '0; exp_ti = '0; exp_td = '0;
    repeat (3) @(negedge clk);
    check("reset_oe", dht_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_dv", data_valid, 0);
    check("reset_err", err, 0);
    check_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_txn("known", {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 0);
    check("known_humi_const", humi_int, 8'h37);
    check("known_temp_const", temp_int, 8'h19);

    do_txn("badsum", {8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, 0);
    do_txn("noresp", 40'h0, 4);
    do_txn("boundary", mk_frame(8'hA5, 8'h3C, 8'h5A, 8'hC3, 1'b0), 1);
    do_txn("abort", mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0), 2);
    do_txn("after_abort", mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0), 0);
    do_txn("start_ignored", mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0), 3);
    do_txn("random", mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                              1'($urandom_range(1, 0))), 0);

    check("dv_err_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
